alu_seq_core: RTL and testbench

//  Parametrised, clocked successor of the 16-op combinational lab ALU. Same 4-bit opcode map,

---
 rtl/alu_seq_core.sv | 167 ++++++++++++++++
 tb/tb_alu_seq_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: 16-op ALU with iterative shift-add MUL / restoring DIV; optional flags via ALU_FLAGS_EN.
// Latency: result valid 1 cycle after accept for single-cycle ops, WIDTH+1 cycles for MUL/DIV.
// Backpressure: result held in dout_r until out_ready; in_ready is high only while IDLE.
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         command_in,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               oe,
  output logic [2*WIDTH-1:0] dout,
  output logic               busy
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]         flags
`endif
);

  localparam int N  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_INV  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_XOR  = 4'd13;
  localparam logic [3:0] OP_XNOR = 4'd14;
  localparam logic [3:0] OP_BUF  = 4'd15;

  // EXEC is the one-cycle result write that every op passes through before DONE.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_EXEC, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cmd_r;
  logic [N-1:0]     a_r, b_r;
  logic [2*N-1:0]   work;       // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [CW-1:0]    cnt;
  logic [2*N-1:0]   dout_r;
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_nxt;
  logic [N:0]       div_sh, div_sub;
  logic [2*N-1:0]   div_nxt;
  logic [N:0]       arith;
  logic             carry_op;
  logic [2*N-1:0]   res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = (command_in == OP_MUL || command_in == OP_DIV) ? S_BUSY : S_EXEC;
      S_BUSY: if (cnt == CW'(N - 1)) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_BUSY);
    out_valid = (state == S_DONE);
  end

  // One iteration of the shift-add multiplier and the restoring divider
  always_comb begin
    mul_sum = {1'b0, work[2*N-1:N]} + (work[0] ? {1'b0, a_r} : {(N+1){1'b0}});
    mul_nxt = {mul_sum, work[N-1:1]};
    div_sh  = {work[2*N-1:N], work[N-1]};
    div_sub = div_sh - {1'b0, b_r};
    if (div_sh >= {1'b0, b_r}) div_nxt = {div_sub[N-1:0], work[N-2:0], 1'b1};
    else                       div_nxt = {div_sh[N-1:0],  work[N-2:0], 1'b0};
  end

  // Operand capture on accept, then WIDTH engine steps (divide-by-zero just counts)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r <= '0;
      a_r   <= '0;
      b_r   <= '0;
      work  <= '0;
      cnt   <= '0;
    end else if (state == S_IDLE && in_valid) begin
      cmd_r <= command_in;
      a_r   <= a;
      b_r   <= b;
      cnt   <= '0;
      work  <= (command_in == OP_MUL) ? {{N{1'b0}}, b} : {{N{1'b0}}, a};
    end else if (state == S_BUSY) begin
      cnt <= cnt + CW'(1);
      if (cmd_r == OP_MUL)   work <= mul_nxt;
      else if (b_r != '0)    work <= div_nxt;
    end
  end

  // Result selection from the captured operands
  always_comb begin
    arith    = '0;
    carry_op = 1'b0;
    res      = '0;
    case (cmd_r)
      OP_ADD:  begin arith = {1'b0, a_r} + {1'b0, b_r};   carry_op = 1'b1; end
      OP_SUB:  begin arith = {1'b0, a_r} - {1'b0, b_r};   carry_op = 1'b1; end
      OP_INC:  begin arith = {1'b0, a_r} + (N+1)'(1);     carry_op = 1'b1; end
      OP_DEC:  begin arith = {1'b0, a_r} - (N+1)'(1);     carry_op = 1'b1; end
      OP_SHL:  begin arith = {a_r, 1'b0};                 carry_op = 1'b1; end
      OP_MUL:  res = work;
      OP_DIV:  res = (b_r == '0) ? {a_r, {N{1'b1}}} : work;
      OP_SHR:  res = {{N{1'b0}}, a_r >> 1};
      OP_AND:  res = {{N{1'b0}}, a_r & b_r};
      OP_OR:   res = {{N{1'b0}}, a_r | b_r};
      OP_INV:  res = {{N{1'b0}}, ~a_r};
      OP_NAND: res = {{N{1'b0}}, ~(a_r & b_r)};
      OP_NOR:  res = {{N{1'b0}}, ~(a_r | b_r)};
      OP_XOR:  res = {{N{1'b0}}, a_r ^ b_r};
      OP_XNOR: res = {{N{1'b0}}, ~(a_r ^ b_r)};
      OP_BUF:  res = {{N{1'b0}}, a_r};
      default: res = '0;
    endcase
    if (carry_op) res = {{(N-1){1'b0}}, arith};
  end

`ifdef ALU_FLAGS_EN
  logic [2:0] flags_r;
  assign flags = flags_r;
`endif

  // Result register: written once in EXEC, held through DONE until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r  <= '0;
`ifdef ALU_FLAGS_EN
      flags_r <= '0;
`endif
    end else if (state == S_EXEC) begin
      dout_r  <= res;
`ifdef ALU_FLAGS_EN
      flags_r <= {(cmd_r == OP_DIV) && (b_r == '0), carry_op & res[N], res == '0};
`endif
    end
  end

  assign dout = oe ? dout_r : {(2*N){1'bz}};

endmodule

// File: tb/tb_alu_seq_core.sv
// Testbench for alu_seq_core (WIDTH=8): vector table, randomized ops against a
// behavioural model, and hand sequences for backpressure, blocking, oe and reset.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  command_in = 4'd0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        oe = 1'b1;
  wire  [15:0] dout;
  logic        busy;
`ifdef ALU_FLAGS_EN
  logic [2:0]  flags;
`endif

  int nvec = 0;
  int nmis = 0;

  alu_seq_core #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .command_in(command_in), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .oe(oe), .dout(dout), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model straight from the opcode table, using plain integer arithmetic
  function automatic logic [15:0] model(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    int unsigned ai = x;
    int unsigned bi = y;
    int unsigned r;
    case (c)
      4'd0:  r = ai + bi;
      4'd1:  r = (ai - bi) & 32'h1FF;
      4'd2:  r = ai + 1;
      4'd3:  r = (ai - 1) & 32'h1FF;
      4'd4:  r = ai * bi;
      4'd5:  r = (bi == 0) ? (ai * 256 + 255) : ((ai % bi) * 256 + ai / bi);
      4'd6:  r = ai * 2;
      4'd7:  r = ai / 2;
      4'd8:  r = ai & bi;
      4'd9:  r = ai | bi;
      4'd10: r = 255 - ai;
      4'd11: r = 255 - (ai & bi);
      4'd12: r = 255 - (ai | bi);
      4'd13: r = ai ^ bi;
      4'd14: r = 255 - (ai ^ bi);
      default: r = ai;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [2:0] model_flags(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r = model(c, x, y);
    logic cy = (c <= 4'd3 || c == 4'd6) ? r[8] : 1'b0;
    return {c == 4'd5 && y == 8'd0, cy, r == 16'd0};
  endfunction

  // Issue one op with out_ready high; report result, latency and busy-cycle count
  task automatic run_op(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] got, output logic [2:0] fl, output int lat, output int bc);
    int w = 0;
    @(negedge clk);
    command_in = c; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    bc = busy ? 1 : 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
    end
    got = dout;
`ifdef ALU_FLAGS_EN
    fl = flags;
`else
    fl = 3'd0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        vt[$];
    logic [15:0] got;
    logic [2:0]  fl;
    int          lat, bc, w;
    logic [3:0]  rc;
    logic [7:0]  rx, ry;

    vt.push_back('{4'd0,  8'hFF, 8'h01, 16'h0100});
    vt.push_back('{4'd0,  8'hFF, 8'hFF, 16'h01FE});
    vt.push_back('{4'd0,  8'h12, 8'h34, 16'h0046});
    vt.push_back('{4'd1,  8'h00, 8'h01, 16'h01FF});
    vt.push_back('{4'd1,  8'h34, 8'h12, 16'h0022});
    vt.push_back('{4'd2,  8'hFF, 8'h00, 16'h0100});
    vt.push_back('{4'd3,  8'h00, 8'h00, 16'h01FF});
    vt.push_back('{4'd4,  8'hFF, 8'hFF, 16'hFE01});
    vt.push_back('{4'd4,  8'h00, 8'h9C, 16'h0000});
    vt.push_back('{4'd5,  8'd200, 8'd7, 16'h041C});
    vt.push_back('{4'd5,  8'd5,  8'd0,  16'h05FF});
    vt.push_back('{4'd6,  8'h80, 8'h00, 16'h0100});
    vt.push_back('{4'd7,  8'h81, 8'h00, 16'h0040});
    vt.push_back('{4'd8,  8'hF0, 8'h3C, 16'h0030});
    vt.push_back('{4'd9,  8'hF0, 8'h3C, 16'h00FC});
    vt.push_back('{4'd10, 8'h0F, 8'h00, 16'h00F0});
    vt.push_back('{4'd11, 8'hF0, 8'h3C, 16'h00CF});
    vt.push_back('{4'd12, 8'hF0, 8'h3C, 16'h0003});
    vt.push_back('{4'd13, 8'hF0, 8'h3C, 16'h00CC});
    vt.push_back('{4'd14, 8'hF0, 8'h3C, 16'h0033});
    vt.push_back('{4'd15, 8'hA5, 8'h00, 16'h00A5});

    // Reset state
    #13;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset dout", dout, 16'h0000);
`ifdef ALU_FLAGS_EN
    chk("reset flags", flags, 3'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Table-driven vectors
    foreach (vt[i]) begin
      run_op(vt[i].cmd, vt[i].x, vt[i].y, got, fl, lat, bc);
      chk($sformatf("vec%0d dout", i), got, vt[i].exp);
      chk($sformatf("vec%0d latency", i), lat, (vt[i].cmd == 4'd4 || vt[i].cmd == 4'd5) ? 9 : 1);
      chk($sformatf("vec%0d busy cycles", i), bc, (vt[i].cmd == 4'd4 || vt[i].cmd == 4'd5) ? 8 : 0);
`ifdef ALU_FLAGS_EN
      chk($sformatf("vec%0d flags", i), fl, model_flags(vt[i].cmd, vt[i].x, vt[i].y));
`endif
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      rc = 4'($urandom_range(0, 15));
      rx = 8'($urandom);
      ry = (i % 10 == 0) ? 8'd0 : 8'($urandom);
      run_op(rc, rx, ry, got, fl, lat, bc);
      chk($sformatf("rand%0d op%0d %0h,%0h", i, rc, rx, ry), got, model(rc, rx, ry));
`ifdef ALU_FLAGS_EN
      chk($sformatf("rand%0d flags", i), fl, model_flags(rc, rx, ry));
`endif
    end

    // ADD FF+01: result one cycle after accept, out_valid pulses once
    @(negedge clk);
    command_in = 4'd0; a = 8'hFF; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("add pulse valid", out_valid, 1);
    chk("add pulse dout", dout, 16'h0100);
`ifdef ALU_FLAGS_EN
    chk("add pulse flags", flags, 3'b010);
`endif
    @(posedge clk); #1;
    chk("add pulse drop", out_valid, 0);

    // MUL FF*FF with the sink stalled for 5 cycles
    @(negedge clk);
    command_in = 4'd4; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
    chk("stall mul dout", dout, 16'hFE01);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall hold%0d", k), {out_valid, in_ready, dout}, {1'b1, 1'b0, 16'hFE01});
    end

    // oe=0 tri-states dout without stalling the handshake; oe=1 shows the held value
    oe = 1'b0; #1;
    nvec++;
    if (dout === 16'hFE01) begin
      nmis++;
      $display("FAIL oe off: got %0h, required not driven", dout);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("oe off handoff", {out_valid, in_ready}, 2'b01);
    oe = 1'b1; #1;
    chk("oe on dout", dout, 16'hFE01);

    // SUB 0-1 held on the input while a MUL is busy: taken only after the handoff
    @(negedge clk);
    command_in = 4'd4; a = 8'd3; b = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    command_in = 4'd1; a = 8'd0; b = 8'd1;
    w = 0;
    while (!out_valid && w < 40) begin @(posedge clk); #1; w++; end
    chk("blocked mul dout", dout, 16'h000F);
    @(posedge clk); #1;
    chk("blocked idle", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("blocked sub taken", in_ready, 0);
    @(posedge clk); #1;
    chk("blocked sub result", {out_valid, dout}, {1'b1, 16'h01FF});
    @(posedge clk); #1;

    // Reset during the 4th BUSY cycle discards the MUL
    @(negedge clk);
    command_in = 4'd4; a = 8'h7F; b = 8'h33; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort dout", dout, 16'h0000);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd5, 8'd200, 8'd7, got, fl, lat, bc);
    chk("post reset div", got, 16'h041C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
